contar_ciclos: RTL and testbench
================================

Name: contar_ciclos

Overview:
- Parametrised successor of the black-period counter used by the paint FSM.
- Counts a runtime-programmable number of prescaled ticks after a one-cycle `init` strobe.
- Adds periodic mode, hold (pause), abort, a live count output and a one-cycle `done` pulse, alongside the sticky `CN` completion flag.
- Sits between the paint controller FSM and the LED-matrix refresh timing. It generates blanking and black-frame intervals of any length without per-length RTL copies.

Parameters:
- WIDTH, 17, width of the tick counter and of `limit` (17 bits covers 100_000).
- PRESCALE, 1, clock cycles per tick; legal range 1 to 255.
- PRE_W, 8, width of the prescaler counter; must satisfy PRESCALE <= 2^PRE_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- init  in  1  start/restart strobe, sampled at posedge.
- limit  in  WIDTH  number of ticks to count; latched when `init` is sampled.
- mode  in  1  0 = one-shot, 1 = periodic; latched with `limit`.
- hold  in  1  level; freezes prescaler and count while high.
- abort  in  1  strobe; returns the block to IDLE without completing.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at each completion.
- CN  out  1  sticky completion flag; cleared by `init` or `abort`.
- count  out  WIDTH  current tick count.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, count=0, pre=0, lim_q=0, mode_q=0, busy=0, done=0, CN=0. Reset takes effect immediately, including mid-RUN; no pulse is issued.
- All outputs are registered. `done` defaults to 0 on every cycle it is not explicitly set.
- Control priority at each posedge: abort > init > hold > counting.
- States are IDLE and RUN.
- IDLE, on init=1 (call this sampling edge E0):
  - Latch lim_q=limit and mode_q=mode; set count=0, pre=0, CN=0.
  - If limit != 0: go to RUN and set busy=1.
  - If limit == 0: stay in IDLE, set done=1 and CN=1 at E0 itself, busy stays 0.
- RUN, abort=1: go to IDLE; busy=0, CN=0, count=0, pre=0; no `done`.
- RUN, init=1: restart exactly as from IDLE, relatching `limit` and `mode`. CN clears.
- RUN, hold=1: pre and count unchanged; `done` is never issued while hold is high.
- RUN, counting:
  - pre increments each cycle. When pre==PRESCALE-1, pre wraps to 0 and that cycle is a tick.
  - On a tick with count==lim_q-1: set done=1 and CN=1, and count wraps to 0.
    - If mode_q=0: go to IDLE, busy=0.
    - If mode_q=1: stay in RUN; the next period starts immediately with no dead cycle.
  - On any other tick: count increments by 1.
- Latency: with hold never asserted, `done` is high in the cycle following edge E0 + lim_q*PRESCALE. In periodic mode, successive `done` pulses are exactly lim_q*PRESCALE cycles apart.
- Each hold cycle delays completion by exactly one cycle.
- `limit`, `mode` and `hold` are ignored while in IDLE except on an `init` edge.
- Arithmetic: unsigned; count never exceeds lim_q-1. limit = 2^WIDTH-1 is legal.
- Simultaneous events:
  - init and a terminal tick on the same edge: init wins, no done pulse.
  - abort and init on the same edge: abort wins, ends in IDLE.
- Reset mid-operation: clears everything, including a pending or high `done`.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release. Expect busy=0, done=0, CN=0, count=0. Pulse rst=0 mid-RUN: all outputs 0 immediately, asynchronously to clk.
- One-shot, PRESCALE=1: init with limit=100_000, mode=0.
  - busy high from E0+1.
  - Exactly one done pulse, in the cycle after E0+100_000.
  - CN=1 from then on; busy=0 thereafter; no further pulses for 1000 cycles.
- Periodic plus prescaler, PRESCALE=4: init with limit=5, mode=1.
  - done pulses at E0+20, +40, +60.
  - count sequence during the first period is 0,1,2,3,4, with each value held for 4 cycles.
- Hold: one-shot, PRESCALE=1, limit=10. Assert hold for 3 cycles starting at E0+4; done occurs at E0+13.
- Abort and restart:
  - limit=50; abort at E0+20 → busy=0, CN=0, no done.
  - A new init with limit=8 issued at E0+30 (call this edge E1) produces done at E1+8.
  - A separate init issued mid-RUN restarts the count at 0.
- Edge cases:
  - limit=0 → done and CN high at E0 with busy never set.
  - limit=1 → done at E0+1.
  - init on the same edge as the terminal tick suppresses that done pulse.

Source files
------------

// File: rtl/contar_ciclos.sv
// Programmable tick counter: counts `limit` prescaled ticks after an `init` strobe,
// one-shot or periodic, with hold, abort, live count, a `done` pulse and a sticky CN flag.
//
// state | meaning
// IDLE  | waiting for init; CN keeps the result of the last run
// RUN   | prescaler and tick count advancing toward lim_q
module contar_ciclos #(
    parameter int WIDTH    = 17,
    parameter int PRESCALE = 1,
    parameter int PRE_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    input  logic             hold,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             CN,
    output logic [WIDTH-1:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] count_d;
    logic             busy_d, done_d, cn_d;
    logic             tick;
    logic [WIDTH-1:0] lim_last;

    assign tick     = (pre_q == PRE_LAST);
    assign lim_last = lim_q - WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            CN      <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            count   <= count_d;
            busy    <= busy_d;
            done    <= done_d;
            CN      <= cn_d;
        end
    end

    // Priority: abort, then init, then hold, then counting.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        count_d = count;
        busy_d  = busy;
        cn_d    = CN;
        done_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            pre_d   = '0;
            count_d = '0;
            busy_d  = 1'b0;
            cn_d    = 1'b0;
        end else if (init) begin
            lim_d   = limit;
            mode_d  = mode;
            count_d = '0;
            pre_d   = '0;
            cn_d    = 1'b0;
            if (limit != '0) begin
                state_d = RUN;
                busy_d  = 1'b1;
            end else begin
                // A zero-length interval completes on the init edge itself.
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cn_d    = 1'b1;
            end
        end else if (state_q == RUN && !hold) begin
            if (tick) begin
                pre_d = '0;
                if (count == lim_last) begin
                    count_d = '0;
                    done_d  = 1'b1;
                    cn_d    = 1'b1;
                    if (!mode_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_contar_ciclos.sv
// Directed bench for contar_ciclos: a per-cycle vector table on a PRESCALE=1 instance,
// plus hand sequences for long counts, prescaled periodic mode, hold, abort and reset.
module tb_contar_ciclos;

    logic        clk;
    logic        rst;
    logic        init;
    logic [16:0] limit;
    logic        mode;
    logic        hold;
    logic        abort;
    logic        busy1, done1, cn1;
    logic [16:0] count1;
    logic        busy4, done4, cn4;
    logic [16:0] count4;

    int n_checks = 0;
    int n_errors = 0;

    contar_ciclos #(.WIDTH(17), .PRESCALE(1), .PRE_W(8)) dut1 (
        .clk(clk), .rst(rst), .init(init), .limit(limit), .mode(mode),
        .hold(hold), .abort(abort), .busy(busy1), .done(done1), .CN(cn1), .count(count1)
    );

    contar_ciclos #(.WIDTH(17), .PRESCALE(4), .PRE_W(8)) dut4 (
        .clk(clk), .rst(rst), .init(init), .limit(limit), .mode(mode),
        .hold(hold), .abort(abort), .busy(busy4), .done(done4), .CN(cn4), .count(count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        init;
        logic [16:0] limit;
        logic        mode;
        logic        hold;
        logic        abort;
        logic        busy;
        logic        done;
        logic        cn;
        logic [16:0] count;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic i, input int l, input logic m, input logic h,
                                input logic a, input logic b, input logic d, input logic c,
                                input int n);
        vec_t v;
        v.init  = i;
        v.limit = 17'(l);
        v.mode  = m;
        v.hold  = h;
        v.abort = a;
        v.busy  = b;
        v.done  = d;
        v.cn    = c;
        v.count = 17'(n);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_init(input logic [16:0] l, input logic m);
        init  = 1'b1;
        limit = l;
        mode  = m;
        step();
        init  = 1'b0;
    endtask

    int pulses;
    int first_k;
    bit busy_dropped;
    bit stray_done;

    initial begin
        rst = 1'b0; init = 1'b0; limit = '0; mode = 1'b0; hold = 1'b0; abort = 1'b0;

        // Reset held for three cycles.
        repeat (3) step();
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_cn", 32'(cn1), 0);
        chk("rst_count", 32'(count1), 0);
        chk("rst_busy4", 32'(busy4), 0);
        rst = 1'b1;
        step();

        //            init lim mode hold abort | busy done cn count
        vecs[0]  = mk(1, 0, 0, 0, 0,   0, 1, 1, 0);  // limit 0 completes at E0
        vecs[1]  = mk(0, 0, 0, 0, 0,   0, 0, 1, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0,   1, 0, 0, 0);  // limit 1
        vecs[3]  = mk(0, 0, 0, 0, 0,   0, 1, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0,   0, 0, 1, 0);
        vecs[5]  = mk(1, 3, 1, 0, 0,   1, 0, 0, 0);  // periodic 3
        vecs[6]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 2);
        vecs[8]  = mk(0, 0, 0, 0, 0,   1, 1, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0,   1, 0, 1, 1);
        vecs[10] = mk(0, 0, 0, 0, 0,   1, 0, 1, 2);
        vecs[11] = mk(1, 2, 0, 0, 0,   1, 0, 0, 0);  // init on terminal tick
        vecs[12] = mk(0, 0, 0, 0, 0,   1, 0, 0, 1);
        vecs[13] = mk(1, 9, 0, 0, 1,   0, 0, 0, 0);  // abort beats init
        vecs[14] = mk(1, 4, 0, 0, 0,   1, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 1, 0,   1, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0,   1, 0, 0, 1);
        vecs[17] = mk(0, 0, 0, 0, 1,   0, 0, 0, 0);
        vecs[18] = mk(1, 2, 0, 0, 0,   1, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0,   1, 0, 0, 1);
        vecs[20] = mk(0, 0, 0, 1, 0,   1, 0, 0, 1);  // hold on terminal tick
        vecs[21] = mk(0, 0, 0, 0, 0,   0, 1, 1, 0);
        vecs[22] = mk(0, 5, 1, 1, 0,   0, 0, 1, 0);  // ignored in IDLE
        vecs[23] = mk(0, 0, 0, 0, 1,   0, 0, 0, 0);  // abort clears CN

        for (int i = 0; i < 24; i++) begin
            init  = vecs[i].init;
            limit = vecs[i].limit;
            mode  = vecs[i].mode;
            hold  = vecs[i].hold;
            abort = vecs[i].abort;
            step();
            chk($sformatf("vec%0d_busy", i), 32'(busy1), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), 32'(done1), 32'(vecs[i].done));
            chk($sformatf("vec%0d_cn", i), 32'(cn1), 32'(vecs[i].cn));
            chk($sformatf("vec%0d_count", i), 32'(count1), 32'(vecs[i].count));
        end
        init = 1'b0; limit = '0; mode = 1'b0; hold = 1'b0; abort = 1'b0;
        step();

        // Long one-shot count crossing bit 16 (length kept within the cycle budget).
        pulse_init(17'd70000, 1'b0);
        chk("big_busy_e0", 32'(busy1), 1);
        pulses = 0; first_k = 0; busy_dropped = 0;
        for (int k = 1; k <= 70500; k++) begin
            step();
            if (done1) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            if (k < 70000 && !busy1) busy_dropped = 1;
            if (k == 65536) chk("big_count_65536", 32'(count1), 65536);
        end
        chk("big_done_cycle", 32'(first_k), 70000);
        chk("big_pulses", 32'(pulses), 1);
        chk("big_busy_held", 32'(busy_dropped), 0);
        chk("big_cn", 32'(cn1), 1);
        chk("big_busy_end", 32'(busy1), 0);

        // Periodic with PRESCALE=4, limit 5.
        pulse_init(17'd5, 1'b1);
        chk("per_count_0", 32'(count4), 0);
        for (int k = 1; k <= 60; k++) begin
            step();
            chk($sformatf("per_done_%0d", k), 32'(done4), 32'((k % 20) == 0));
            if (k < 20) chk($sformatf("per_count_%0d", k), 32'(count4), 32'((k / 4) % 5));
        end
        chk("per_busy", 32'(busy4), 1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("per_abort_busy", 32'(busy4), 0);

        // Hold for three cycles starting at E0+4 delays done to E0+13.
        pulse_init(17'd10, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            hold = (k >= 4 && k <= 6);
            step();
            chk($sformatf("hold_done_%0d", k), 32'(done1), 32'(k == 13));
        end
        hold = 1'b0;

        // Abort at E0+20, restart at E0+30.
        pulse_init(17'd50, 1'b0);
        stray_done = 0;
        for (int k = 1; k <= 29; k++) begin
            abort = (k == 20);
            step();
            if (done1) stray_done = 1;
            if (k == 20) begin
                chk("abort_busy", 32'(busy1), 0);
                chk("abort_cn", 32'(cn1), 0);
                chk("abort_count", 32'(count1), 0);
            end
        end
        abort = 1'b0;
        chk("abort_no_done", 32'(stray_done), 0);
        pulse_init(17'd8, 1'b0);
        for (int j = 1; j <= 9; j++) begin
            step();
            chk($sformatf("restart_done_%0d", j), 32'(done1), 32'(j == 8));
        end

        // Init mid-run restarts at zero.
        pulse_init(17'd20, 1'b0);
        repeat (5) step();
        chk("midinit_before", 32'(count1), 5);
        pulse_init(17'd20, 1'b0);
        chk("midinit_zero", 32'(count1), 0);
        repeat (3) step();
        chk("midinit_after", 32'(count1), 3);

        // Asynchronous reset while done is high.
        pulse_init(17'd3, 1'b1);
        repeat (3) step();
        chk("arst_pre_done", 32'(done1), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy1), 0);
        chk("arst_done", 32'(done1), 0);
        chk("arst_cn", 32'(cn1), 0);
        chk("arst_count", 32'(count1), 0);
        chk("arst_busy4", 32'(busy4), 0);
        #1 rst = 1'b1;
        step();
        chk("arst_stays_idle", 32'(busy1), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
